// File: rtl/div_sign_seq_pkg.sv
// rtl/div_sign_seq_pkg.sv - shared muldiv package: sequencer states, INT_MIN, timeout counter width
package div_sign_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  // Wide enough for any TIMEOUT_CYC up to 255
  localparam int TMO_W = 8;

endpackage

// File: rtl/div_sign_seq_neg_cond.sv
// rtl/div_sign_seq_neg_cond.sv - conditional two's-complement negate, WIDTH bits
module div_sign_seq_neg_cond #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic             neg,
  output logic [WIDTH-1:0] y
);

  assign y = neg ? (~x + WIDTH'(1)) : x;

endmodule

// File: rtl/div_sign_seq.sv
// rtl/div_sign_seq.sv - signed-division sequencer around an unsigned divider; DIV_ZERO_FASTPATH_EN skips the divider on /0 and overflow
module div_sign_seq
  import div_sign_seq_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int TIMEOUT_CYC = 40
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_DIV,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_ready,
  input  logic             div_exception,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_rem,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL = WIDTH'(INT_MIN);

  state_t state, next_state;

  logic             sa_now, sb_now, zero_now, ovf_now;
  logic             sa_r, sb_r, zero_r, ovf_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] mag_a, mag_b, fix_q, fix_r;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             load, fin_zero, fin_ovf, fin_tmo;
  logic [WIDTH-1:0] fin_a, res_q, res_r;
  logic             res_exc;

  assign sa_now   = is_signed & operand_a[WIDTH-1];
  assign sb_now   = is_signed & operand_b[WIDTH-1];
  assign zero_now = (operand_b == '0);
  assign ovf_now  = is_signed && (operand_a == MIN_VAL) && (operand_b == '1);
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  div_sign_seq_neg_cond #(.WIDTH(WIDTH)) u_neg_a (.x(operand_a),     .neg(sa_now),      .y(mag_a));
  div_sign_seq_neg_cond #(.WIDTH(WIDTH)) u_neg_b (.x(operand_b),     .neg(sb_now),      .y(mag_b));
  div_sign_seq_neg_cond #(.WIDTH(WIDTH)) u_neg_q (.x(div_quotient),  .neg(sa_r ^ sb_r), .y(fix_q));
  div_sign_seq_neg_cond #(.WIDTH(WIDTH)) u_neg_r (.x(div_remainder), .neg(sa_r),        .y(fix_r));

  always_comb begin
    next_state     = state;
    load           = 1'b0;
    fin_zero       = zero_r;
    fin_ovf        = ovf_r;
    fin_tmo        = 1'b0;
    fin_a          = a_r;
    div_start      = 1'b0;
    data_resultRDY = 1'b0;
    busy           = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (ctrl_DIV) begin
          next_state = LAUNCH;
`ifdef DIV_ZERO_FASTPATH_EN
          if (zero_now || ovf_now) begin
            next_state = DONE;
            load       = 1'b1;
            fin_zero   = zero_now;
            fin_ovf    = ovf_now;
            fin_a      = operand_a;
          end
`endif
        end
      end
      LAUNCH: begin
        div_start  = 1'b1;
        next_state = WAIT;
      end
      WAIT: begin
        // A ready on the last counted cycle still wins over the timeout
        if (div_ready) begin
          next_state = DONE;
          load       = 1'b1;
        end else if (tmo_hit) begin
          next_state = DONE;
          load       = 1'b1;
          fin_tmo    = 1'b1;
        end
      end
      DONE: begin
        data_resultRDY = 1'b1;
        next_state     = IDLE;
      end
      default: next_state = IDLE;
    endcase

    if (fin_zero) begin
      res_q   = '0;
      res_r   = fin_a;
      res_exc = 1'b1;
    end else if (fin_ovf) begin
      res_q   = MIN_VAL;
      res_r   = '0;
      res_exc = 1'b1;
    end else if (fin_tmo) begin
      res_q   = '0;
      res_r   = '0;
      res_exc = 1'b1;
    end else begin
      res_q   = fix_q;
      res_r   = fix_r;
      res_exc = div_exception;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      sa_r           <= 1'b0;
      sb_r           <= 1'b0;
      zero_r         <= 1'b0;
      ovf_r          <= 1'b0;
      a_r            <= '0;
      div_a          <= '0;
      div_b          <= '0;
      data_result    <= '0;
      data_rem       <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= next_state;
      if (state == IDLE && ctrl_DIV) begin
        sa_r   <= sa_now;
        sb_r   <= sb_now;
        zero_r <= zero_now;
        ovf_r  <= ovf_now;
        a_r    <= operand_a;
        div_a  <= mag_a;
        div_b  <= mag_b;
      end
      if (state == WAIT && !div_ready) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end else begin
        tmo_cnt <= '0;
      end
      if (load) begin
        data_result    <= res_q;
        data_rem       <= res_r;
        data_exception <= res_exc;
      end
    end
  end

endmodule

// File: tb/tb_div_sign_seq.sv
// tb/tb_div_sign_seq.sv - directed vector bench for div_sign_seq with a behavioural divider response
module tb_div_sign_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_DIV;
  logic        is_signed;
  logic [31:0] operand_a, operand_b;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic [31:0] div_quotient, div_remainder;
  logic        div_ready, div_exception;
  logic [31:0] data_result, data_rem;
  logic        data_exception, data_resultRDY, busy;

  int checks = 0;
  int errors = 0;

  div_sign_seq #(.WIDTH(32), .TIMEOUT_CYC(40)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .is_signed      (is_signed),
    .operand_a      (operand_a),
    .operand_b      (operand_b),
    .div_start      (div_start),
    .div_a          (div_a),
    .div_b          (div_b),
    .div_quotient   (div_quotient),
    .div_remainder  (div_remainder),
    .div_ready      (div_ready),
    .div_exception  (div_exception),
    .data_result    (data_result),
    .data_rem       (data_rem),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b;
    logic [31:0] exp_da, exp_db;
    logic [31:0] exp_q, exp_r;
    logic        dexc;
    logic        exp_exc;
    logic        fast;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic respond(input logic [31:0] da, input logic [31:0] db, input logic dexc);
    div_quotient  = (db == 0) ? 32'hFFFF_FFFF : da / db;
    div_remainder = (db == 0) ? da : da % db;
    div_exception = dexc;
    div_ready     = 1'b1;
  endtask

  task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    is_signed = sgn;
    operand_a = a;
    operand_b = b;
    ctrl_DIV  = 1'b1;
    tick();
    ctrl_DIV  = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    logic bad;
    v = vecs[i];
    start_op(v.sgn, v.a, v.b);
`ifdef DIV_ZERO_FASTPATH_EN
    if (v.fast) begin
      check($sformatf("v%0d fast rdy", i), data_resultRDY, 1);
      check($sformatf("v%0d fast nostart", i), div_start, 0);
      check($sformatf("v%0d q", i), data_result, v.exp_q);
      check($sformatf("v%0d r", i), data_rem, v.exp_r);
      check($sformatf("v%0d exc", i), data_exception, v.exp_exc);
      tick();
      check($sformatf("v%0d busy end", i), busy, 0);
      return;
    end
`endif
    check($sformatf("v%0d start", i), div_start, 1);
    check($sformatf("v%0d busy", i), busy, 1);
    check($sformatf("v%0d div_a", i), div_a, v.exp_da);
    check($sformatf("v%0d div_b", i), div_b, v.exp_db);
    bad = 1'b0;
    repeat (32) begin
      tick();
      if (div_start || data_resultRDY || !busy) bad = 1'b1;
    end
    check($sformatf("v%0d quiet wait", i), bad, 0);
    check($sformatf("v%0d div_b held", i), div_b, v.exp_db);
    respond(v.exp_da, v.exp_db, v.dexc);
    tick();
    div_ready     = 1'b0;
    div_exception = 1'b0;
    check($sformatf("v%0d rdy at 34", i), data_resultRDY, 1);
    check($sformatf("v%0d q", i), data_result, v.exp_q);
    check($sformatf("v%0d r", i), data_rem, v.exp_r);
    check($sformatf("v%0d exc", i), data_exception, v.exp_exc);
    tick();
    check($sformatf("v%0d rdy pulse", i), data_resultRDY, 0);
    check($sformatf("v%0d busy end", i), busy, 0);
    check($sformatf("v%0d q held", i), data_result, v.exp_q);
  endtask

  initial begin
    int cyc;
    logic bad;

    //           sgn   a             b             div_a         div_b         q             r             dexc  exc   fast
    vecs[0] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'h00000007, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000007, 32'h00000002, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000007, 32'h00000002, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h00000005, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 32'h00000005, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 32'hFFFFFFFB, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 32'hFFFFFFFB, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 32'h00000009, 32'h00000003, 32'h00000009, 32'h00000003, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1'b0};

    reset         = 1'b1;
    ctrl_DIV      = 1'b0;
    is_signed     = 1'b0;
    operand_a     = '0;
    operand_b     = '0;
    div_quotient  = '0;
    div_remainder = '0;
    div_ready     = 1'b0;
    div_exception = 1'b0;
    tick();
    tick();
    check("reset div_start", div_start, 0);
    check("reset div_a", div_a, 0);
    check("reset div_b", div_b, 0);
    check("reset result", data_result, 0);
    check("reset rem", data_rem, 0);
    check("reset exc", data_exception, 0);
    check("reset rdy", data_resultRDY, 0);
    check("reset busy", busy, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(i);

    // Stale ready in IDLE and LAUNCH must not complete the operation
    div_ready = 1'b1;
    start_op(1'b1, 32'h00000064, 32'h00000007);
    tick();
    div_ready = 1'b0;
    check("stale ready no rdy", data_resultRDY, 0);
    check("stale ready busy", busy, 1);
    repeat (3) tick();
    respond(32'h64, 32'h7, 1'b0);
    tick();
    div_ready = 1'b0;
    check("stale ready later rdy", data_resultRDY, 1);
    check("stale ready q", data_result, 32'h0000000E);
    tick();

    // Second ctrl_DIV while waiting is dropped
    start_op(1'b1, 32'h00000064, 32'h00000007);
    repeat (3) tick();
    start_op(1'b0, 32'h00000001, 32'h00000001);
    check("ignored ctrl div_a", div_a, 32'h00000064);
    check("ignored ctrl div_b", div_b, 32'h00000007);
    check("ignored ctrl nostart", div_start, 0);
    repeat (4) tick();
    respond(32'h64, 32'h7, 1'b0);
    tick();
    div_ready = 1'b0;
    check("ignored ctrl rdy", data_resultRDY, 1);
    check("ignored ctrl q", data_result, 32'h0000000E);
    check("ignored ctrl r", data_rem, 32'h00000002);
    tick();
    tick();
    check("ignored ctrl no relaunch", div_start, 0);
    check("ignored ctrl idle", busy, 0);

    // Reset in WAIT aborts silently
    start_op(1'b1, 32'h00000064, 32'h00000007);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort rdy", data_resultRDY, 0);
    check("abort div_b", div_b, 0);
    tick();
    reset = 1'b0;
    respond(32'h64, 32'h7, 1'b0);
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (data_resultRDY || busy) bad = 1'b1;
    end
    div_ready = 1'b0;
    check("abort no rdy", bad, 0);
    run_vec(0);

    // Divider never answers
    start_op(1'b0, 32'h00000009, 32'h00000003);
    cyc = 1;
    while (!data_resultRDY && cyc < 100) begin
      tick();
      cyc++;
    end
    check("timeout cycle", cyc, 42);
    check("timeout q", data_result, 0);
    check("timeout r", data_rem, 0);
    check("timeout exc", data_exception, 1);
    tick();
    check("timeout idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
